mod_n_updown_counter: RTL and testbench

Parametrised synchronous modulo-N counter: the next-generation, generalised form of the team's fixed 4-bit synchronous up counter. It adds programmable width and modulus, up/down direction, count enable, parallel load, a wrap-or-saturate mode, and cascade outputs. It is the general-purpose count element for timers, prescalers and digit counters, e.g. BCD digits built from chained MODULUS=10 instances.

---
 rtl/mod_n_updown_counter.sv | 41 ++++
 tb/tb_mod_n_updown_counter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_n_updown_counter.sv
// mod_n_updown_counter: parametrised modulo-N up/down counter with parallel load,
// wrap-or-saturate terminal behaviour and a combinational cascade terminal count.
module mod_n_updown_counter #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             ovf
);
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
    // one bit wider so the clamp compare stays meaningful when MODULUS == 2^WIDTH
    localparam logic [WIDTH:0]   LIM = (WIDTH + 1)'(MODULUS);
    logic [WIDTH-1:0] q_q, q_d;
    logic             ovf_q, ovf_d, term;
    assign term  = up ? (q_q == MAX) : (q_q == '0);
    assign tc    = en & term;
    assign ovf_d = tc & ~load;
    assign q_d   = load ? (({1'b0, d} >= LIM) ? MAX : d)
                 : !en  ? q_q
                 : term ? (SATURATE ? q_q : (up ? '0 : MAX))
                 : up   ? q_q + 1'b1 : q_q - 1'b1;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            ovf_q <= ovf_d;
        end
    end
    assign Q   = q_q;
    assign ovf = ovf_q;
endmodule

// File: tb/tb_mod_n_updown_counter.sv
// tb_mod_n_updown_counter: scenario tasks plus randomized stimulus checked against
// an arithmetic modulo-N reference model; covers wrap, saturate, 2^W modulus and cascade.
module tb_mod_n_updown_counter;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic       rst_n = 1'b0, en = 1'b0, up = 1'b0, load = 1'b0;
    logic [3:0] d = '0;
    logic [3:0] q_m, q_s, q_p;
    logic       tc_m, tc_s, tc_p, ovf_m, ovf_s, ovf_p;
    logic       c_rst_n = 1'b0, c_en = 1'b0;
    logic [3:0] q_c0, q_c1;
    logic       tc_c0, tc_c1, ovf_c0, ovf_c1;
    int total = 0, bad = 0;
    int mq = 0, sq = 0, pq = 0;
    bit movf, sovf, povf, e_tc_m, e_tc_s, e_tc_p;
    logic a_tc_m, a_tc_s, a_tc_p;

    mod_n_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) dut_m (
        .clk(clk), .reset_n(rst_n), .en(en), .up(up), .load(load), .d(d),
        .Q(q_m), .tc(tc_m), .ovf(ovf_m));
    mod_n_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) dut_s (
        .clk(clk), .reset_n(rst_n), .en(en), .up(up), .load(load), .d(d),
        .Q(q_s), .tc(tc_s), .ovf(ovf_s));
    mod_n_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) dut_p (
        .clk(clk), .reset_n(rst_n), .en(en), .up(up), .load(load), .d(d),
        .Q(q_p), .tc(tc_p), .ovf(ovf_p));
    mod_n_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) dut_c0 (
        .clk(clk), .reset_n(c_rst_n), .en(c_en), .up(1'b1), .load(1'b0), .d(4'd0),
        .Q(q_c0), .tc(tc_c0), .ovf(ovf_c0));
    mod_n_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) dut_c1 (
        .clk(clk), .reset_n(c_rst_n), .en(tc_c0), .up(1'b1), .load(1'b0), .d(4'd0),
        .Q(q_c1), .tc(tc_c1), .ovf(ovf_c1));

    function automatic bit at_end(int q, bit u, int m);
        return u ? (q == m - 1) : (q == 0);
    endfunction
    function automatic int model_q(int q, bit r, bit l, bit e, bit u, int dv, int m, bit sat);
        if (!r) return 0;
        if (l) return (dv > m - 1) ? m - 1 : dv;
        if (!e) return q;
        if (sat && at_end(q, u, m)) return q;
        return (q + (u ? 1 : m - 1)) % m;
    endfunction
    function automatic bit model_ovf(int q, bit r, bit l, bit e, bit u, int m);
        return r && !l && e && at_end(q, u, m);
    endfunction

    task automatic tick(input bit r, input bit l, input bit e, input bit u, input int dv);
        rst_n = r; load = l; en = e; up = u; d = 4'(dv);
        #1;
        a_tc_m = tc_m; a_tc_s = tc_s; a_tc_p = tc_p;
        e_tc_m = e && at_end(mq, u, 10);
        e_tc_s = e && at_end(sq, u, 10);
        e_tc_p = e && at_end(pq, u, 16);
        @(posedge clk);
        movf = model_ovf(mq, r, l, e, u, 10); mq = model_q(mq, r, l, e, u, dv, 10, 1'b0);
        sovf = model_ovf(sq, r, l, e, u, 10); sq = model_q(sq, r, l, e, u, dv, 10, 1'b1);
        povf = model_ovf(pq, r, l, e, u, 16); pq = model_q(pq, r, l, e, u, dv, 16, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_reset();
        tick(1'b0, 1'b1, 1'b1, 1'b1, 5);
        tick(1'b0, 1'b1, 1'b1, 1'b0, 7);
        total++;
        if (q_m !== 4'd0 || ovf_m !== 1'b0) begin
            bad++; $display("FAIL reset_m Q=%0d ovf=%b want Q=0 ovf=0", q_m, ovf_m);
        end
        total++;
        if (q_s !== 4'd0 || ovf_s !== 1'b0) begin
            bad++; $display("FAIL reset_s Q=%0d ovf=%b want Q=0 ovf=0", q_s, ovf_s);
        end
        total++;
        if (q_p !== 4'd0 || ovf_p !== 1'b0) begin
            bad++; $display("FAIL reset_p Q=%0d ovf=%b want Q=0 ovf=0", q_p, ovf_p);
        end
    endtask

    task automatic test_up_wrap();
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, 1'b0, 1'b1, 1'b1, 0);
            total++;
            if (q_m !== 4'(mq) || ovf_m !== movf || a_tc_m !== e_tc_m) begin
                bad++;
                $display("FAIL up_wrap step=%0d Q=%0d ovf=%b tc=%b want Q=%0d ovf=%b tc=%b",
                         i, q_m, ovf_m, a_tc_m, mq, movf, e_tc_m);
            end
        end
        total++;
        if (q_m !== 4'd2) begin
            bad++; $display("FAIL up_wrap_final Q=%0d want 2", q_m);
        end
    endtask

    task automatic test_down_wrap();
        tick(1'b1, 1'b1, 1'b0, 1'b0, 2);
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b0, 1'b1, 1'b0, 0);
            total++;
            if (q_m !== 4'(mq) || ovf_m !== movf || a_tc_m !== e_tc_m) begin
                bad++;
                $display("FAIL down_wrap step=%0d Q=%0d ovf=%b tc=%b want Q=%0d ovf=%b tc=%b",
                         i, q_m, ovf_m, a_tc_m, mq, movf, e_tc_m);
            end
        end
        total++;
        if (q_m !== 4'd8 || ovf_m !== 1'b0) begin
            bad++; $display("FAIL down_wrap_final Q=%0d ovf=%b want Q=8 ovf=0", q_m, ovf_m);
        end
    endtask

    task automatic test_load();
        tick(1'b1, 1'b1, 1'b1, 1'b1, 5);
        total++;
        if (q_m !== 4'd5 || ovf_m !== 1'b0) begin
            bad++; $display("FAIL load_priority Q=%0d ovf=%b want Q=5 ovf=0", q_m, ovf_m);
        end
        tick(1'b1, 1'b1, 1'b0, 1'b1, 13);
        total++;
        if (q_m !== 4'd9 || ovf_m !== 1'b0) begin
            bad++; $display("FAIL load_clamp Q=%0d ovf=%b want Q=9 ovf=0", q_m, ovf_m);
        end
        total++;
        if (q_p !== 4'd13) begin
            bad++; $display("FAIL load_noclamp_p Q=%0d want 13", q_p);
        end
        tick(1'b1, 1'b1, 1'b1, 1'b1, 9);
        total++;
        if (q_m !== 4'd9 || ovf_m !== 1'b0) begin
            bad++; $display("FAIL load_at_tc Q=%0d ovf=%b want Q=9 ovf=0", q_m, ovf_m);
        end
    endtask

    task automatic test_saturate();
        tick(1'b1, 1'b1, 1'b0, 1'b1, 8);
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0, 1'b1, 1'b1, 0);
            total++;
            if (q_s !== 4'(sq) || ovf_s !== sovf || a_tc_s !== e_tc_s) begin
                bad++;
                $display("FAIL saturate step=%0d Q=%0d ovf=%b tc=%b want Q=%0d ovf=%b tc=%b",
                         i, q_s, ovf_s, a_tc_s, sq, sovf, e_tc_s);
            end
        end
        total++;
        if (q_s !== 4'd9 || ovf_s !== 1'b1) begin
            bad++; $display("FAIL saturate_hold Q=%0d ovf=%b want Q=9 ovf=1", q_s, ovf_s);
        end
        tick(1'b1, 1'b0, 1'b1, 1'b0, 0);
        total++;
        if (q_s !== 4'd8 || ovf_s !== 1'b0) begin
            bad++; $display("FAIL saturate_down Q=%0d ovf=%b want Q=8 ovf=0", q_s, ovf_s);
        end
    endtask

    task automatic test_pow2();
        tick(1'b1, 1'b1, 1'b0, 1'b1, 15);
        tick(1'b1, 1'b0, 1'b1, 1'b1, 0);
        total++;
        if (q_p !== 4'd0 || ovf_p !== 1'b1) begin
            bad++; $display("FAIL pow2_up Q=%0d ovf=%b want Q=0 ovf=1", q_p, ovf_p);
        end
        tick(1'b1, 1'b0, 1'b1, 1'b0, 0);
        total++;
        if (q_p !== 4'd15 || ovf_p !== 1'b1) begin
            bad++; $display("FAIL pow2_down Q=%0d ovf=%b want Q=15 ovf=1", q_p, ovf_p);
        end
    endtask

    task automatic test_reset_mid();
        tick(1'b0, 1'b0, 1'b0, 1'b1, 0);
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, 1'b1, 1'b1, 0);
        total++;
        if (q_m !== 4'd6) begin
            bad++; $display("FAIL reset_mid_pre Q=%0d want 6", q_m);
        end
        tick(1'b0, 1'b1, 1'b1, 1'b1, 3);
        total++;
        if (q_m !== 4'd0 || ovf_m !== 1'b0) begin
            bad++; $display("FAIL reset_mid Q=%0d ovf=%b want Q=0 ovf=0", q_m, ovf_m);
        end
        for (int i = 1; i <= 3; i++) begin
            tick(1'b1, 1'b0, 1'b1, 1'b1, 0);
            total++;
            if (q_m !== 4'(i)) begin
                bad++; $display("FAIL reset_mid_resume Q=%0d want %0d", q_m, i);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(0, 19) != 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 15));
            total++;
            if (q_m !== 4'(mq) || ovf_m !== movf || a_tc_m !== e_tc_m) begin
                bad++;
                $display("FAIL random_m i=%0d Q=%0d ovf=%b tc=%b want Q=%0d ovf=%b tc=%b",
                         i, q_m, ovf_m, a_tc_m, mq, movf, e_tc_m);
            end
            total++;
            if (q_s !== 4'(sq) || ovf_s !== sovf || a_tc_s !== e_tc_s) begin
                bad++;
                $display("FAIL random_s i=%0d Q=%0d ovf=%b tc=%b want Q=%0d ovf=%b tc=%b",
                         i, q_s, ovf_s, a_tc_s, sq, sovf, e_tc_s);
            end
            total++;
            if (q_p !== 4'(pq) || ovf_p !== povf || a_tc_p !== e_tc_p) begin
                bad++;
                $display("FAIL random_p i=%0d Q=%0d ovf=%b tc=%b want Q=%0d ovf=%b tc=%b",
                         i, q_p, ovf_p, a_tc_p, pq, povf, e_tc_p);
            end
        end
    endtask

    task automatic test_cascade();
        c_rst_n = 1'b0; c_en = 1'b0;
        @(posedge clk); @(negedge clk);
        c_rst_n = 1'b1; c_en = 1'b1;
        for (int n = 1; n <= 25; n++) begin
            #1;
            total++;
            if (tc_c0 !== (((n - 1) % 10) == 9)) begin
                bad++; $display("FAIL cascade_tc n=%0d tc=%b want %b", n, tc_c0, ((n - 1) % 10) == 9);
            end
            @(posedge clk); @(negedge clk);
            total++;
            if (q_c1 !== 4'(n / 10) || q_c0 !== 4'(n % 10)) begin
                bad++; $display("FAIL cascade n=%0d got %0d%0d want %0d", n, q_c1, q_c0, n);
            end
        end
        total++;
        if (q_c1 !== 4'd2 || q_c0 !== 4'd5) begin
            bad++; $display("FAIL cascade_final got %0d%0d want 25", q_c1, q_c0);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_load();
        test_saturate();
        test_pow2();
        test_reset_mid();
        test_random();
        test_cascade();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
